// File: rtl/riscv_defines.sv
// Shared definitions for the execute-to-writeback buffer.
//   EX_WB_DEPTH       default number of buffer entries
//   EX_WB_ADDR_WIDTH  register-file address width carried in each entry
//   ex_wb_entry_t     one buffered ALU result with its writeback tag
package riscv_defines;

  localparam int EX_WB_DEPTH      = 2;
  localparam int EX_WB_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [31:0]                 wdata;
    logic [EX_WB_ADDR_WIDTH-1:0] waddr;
    logic                        we;
    logic                        cmp;
  } ex_wb_entry_t;

endpackage

// File: rtl/riscv_ex_wb_fwd_mux.sv
// Forwarding lookup for one decode read port.
//   entries  buffer storage, indexed by slot
//   valid    per-slot valid mask
//   wptr     write pointer; the slot it names is the oldest when the buffer is full
//   raddr    decode read address
//   hit      a valid buffered entry will write raddr
//   data     result of the youngest such entry, 0 on no hit
module riscv_ex_wb_fwd_mux
  import riscv_defines::*;
#(
  parameter int DEPTH = EX_WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  ex_wb_entry_t [DEPTH-1:0]            entries,
  input  logic [DEPTH-1:0]                    valid,
  input  logic [PTR_W-1:0]                    wptr,
  input  logic [EX_WB_ADDR_WIDTH-1:0]         raddr,
  output logic                                hit,
  output logic [31:0]                         data
);

  // Slots are visited oldest to youngest (starting at wptr), so a later match
  // overrides an earlier one and the youngest writer wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = wptr + PTR_W'(i);
      if (valid[idx] && entries[idx].we && (raddr != '0) &&
          (entries[idx].waddr == raddr)) begin
        hit  = 1'b1;
        data = entries[idx].wdata;
      end
    end
  end

endmodule

// File: rtl/riscv_ex_wb_buffer.sv
// Registered execute-to-writeback stage behind the ALU.
//   ex_valid_i/alu_ready_i/alu_*/regfile_*  incoming ALU result and write tag
//   flush_i                                  drop all buffered and incoming entries
//   ex_ready_o                               buffer not full (registered state only)
//   wb_*                                     head entry with valid/ready handshake
//   fwd_raddr_*_i / fwd_hit_*_o / fwd_data_*_o  operand forwarding to decode
//   stall_cnt_o                              cycles with ex_valid_i=1 and ex_ready_o=0
module riscv_ex_wb_buffer
  import riscv_defines::*;
#(
  parameter int DEPTH      = EX_WB_DEPTH,
  parameter int ADDR_WIDTH = EX_WB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  input  logic                  alu_ready_i,
  input  logic [31:0]           alu_result_i,
  input  logic                  alu_cmp_i,
  input  logic [ADDR_WIDTH-1:0] regfile_waddr_i,
  input  logic                  regfile_we_i,
  input  logic                  flush_i,
  output logic                  ex_ready_o,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [ADDR_WIDTH-1:0] wb_waddr_o,
  output logic [31:0]           wb_wdata_o,
  output logic                  wb_we_o,
  output logic                  wb_cmp_o,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr_b_i,
  output logic                  fwd_hit_a_o,
  output logic [31:0]           fwd_data_a_o,
  output logic                  fwd_hit_b_o,
  output logic [31:0]           fwd_data_b_o,
  output logic [31:0]           stall_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (ADDR_WIDTH != EX_WB_ADDR_WIDTH) begin : g_bad_addr_width
    $error("ADDR_WIDTH must equal EX_WB_ADDR_WIDTH");
  end
  if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
    $error("DEPTH must be 2 or 4");
  end

  ex_wb_entry_t [DEPTH-1:0] mem;
  logic [DEPTH-1:0]         valid_q;
  logic [PTR_W-1:0]         wptr_q;
  logic [PTR_W-1:0]         rptr_q;
  logic [CNT_W-1:0]         count_q;
  logic [31:0]              stall_cnt_q;

  ex_wb_entry_t             new_entry;
  ex_wb_entry_t             head;
  logic                     push;
  logic                     pop;

  assign ex_ready_o = (count_q != CNT_W'(DEPTH));
  assign wb_valid_o = (count_q != '0);
  assign push       = ex_valid_i & alu_ready_i & ex_ready_o & ~flush_i;
  assign pop        = wb_valid_o & wb_ready_i & ~flush_i;

  // Writes to x0 are buffered like any other result but never reach the
  // register file and never forward.
  always_comb begin
    new_entry.wdata = alu_result_i;
    new_entry.waddr = regfile_waddr_i;
    new_entry.we    = regfile_we_i & (regfile_waddr_i != '0);
    new_entry.cmp   = alu_cmp_i;
  end

  // Stale slots are masked here, so the storage itself needs no reset.
  assign head        = wb_valid_o ? mem[rptr_q] : '0;
  assign wb_waddr_o  = head.waddr;
  assign wb_wdata_o  = head.wdata;
  assign wb_we_o     = head.we;
  assign wb_cmp_o    = head.cmp;
  assign stall_cnt_o = stall_cnt_q;

  // NOTE: storage is deliberately left out of reset; the valid bits alone
  // decide whether a slot's contents are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      valid_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      // The stall counter keeps counting through a flush.
      if (ex_valid_i && !ex_ready_o) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_i) begin
        valid_q <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          wptr_q          <= wptr_q + PTR_W'(1);
          valid_q[wptr_q] <= 1'b1;
        end
        // push and pop never target the same slot: that needs full (no push)
        // or empty (no pop).
        if (pop) begin
          rptr_q          <= rptr_q + PTR_W'(1);
          valid_q[rptr_q] <= 1'b0;
        end
        if (push && !pop) begin
          count_q <= count_q + CNT_W'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

  riscv_ex_wb_fwd_mux #(.DEPTH(DEPTH)) u_fwd_a (
    .entries (mem),
    .valid   (valid_q),
    .wptr    (wptr_q),
    .raddr   (fwd_raddr_a_i),
    .hit     (fwd_hit_a_o),
    .data    (fwd_data_a_o)
  );

  riscv_ex_wb_fwd_mux #(.DEPTH(DEPTH)) u_fwd_b (
    .entries (mem),
    .valid   (valid_q),
    .wptr    (wptr_q),
    .raddr   (fwd_raddr_b_i),
    .hit     (fwd_hit_b_o),
    .data    (fwd_data_b_o)
  );

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count_q == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_riscv_ex_wb_buffer.sv
// Self-checking bench for riscv_ex_wb_buffer (DEPTH=2, ADDR_WIDTH=5).
module tb_riscv_ex_wb_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i;
  logic        alu_ready_i;
  logic [31:0] alu_result_i;
  logic        alu_cmp_i;
  logic [4:0]  regfile_waddr_i;
  logic        regfile_we_i;
  logic        flush_i;
  logic        ex_ready_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        wb_we_o;
  logic        wb_cmp_o;
  logic [4:0]  fwd_raddr_a_i;
  logic [4:0]  fwd_raddr_b_i;
  logic        fwd_hit_a_o;
  logic [31:0] fwd_data_a_o;
  logic        fwd_hit_b_o;
  logic [31:0] fwd_data_b_o;
  logic [31:0] stall_cnt_o;

  int n_total = 0;
  int n_pass  = 0;

  riscv_ex_wb_buffer #(.DEPTH(2), .ADDR_WIDTH(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid_i      (ex_valid_i),
    .alu_ready_i     (alu_ready_i),
    .alu_result_i    (alu_result_i),
    .alu_cmp_i       (alu_cmp_i),
    .regfile_waddr_i (regfile_waddr_i),
    .regfile_we_i    (regfile_we_i),
    .flush_i         (flush_i),
    .ex_ready_o      (ex_ready_o),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_waddr_o      (wb_waddr_o),
    .wb_wdata_o      (wb_wdata_o),
    .wb_we_o         (wb_we_o),
    .wb_cmp_o        (wb_cmp_o),
    .fwd_raddr_a_i   (fwd_raddr_a_i),
    .fwd_raddr_b_i   (fwd_raddr_b_i),
    .fwd_hit_a_o     (fwd_hit_a_o),
    .fwd_data_a_o    (fwd_data_a_o),
    .fwd_hit_b_o     (fwd_hit_b_o),
    .fwd_data_b_o    (fwd_data_b_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic        ar;
    logic [31:0] res;
    logic        cmp;
    logic [4:0]  wa;
    logic        we;
    logic        wr;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        e_valid;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_we;
    logic        e_cmp;
    logic        e_rdy;
    logic        e_ha;
    logic [31:0] e_da;
    logic        e_hb;
    logic [31:0] e_db;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic ev, logic ar, logic [31:0] res, logic cmp,
                              logic [4:0] wa, logic we, logic wr,
                              logic [4:0] ra, logic [4:0] rb,
                              logic e_valid, logic [4:0] e_waddr,
                              logic [31:0] e_wdata, logic e_we, logic e_cmp,
                              logic e_rdy, logic e_ha, logic [31:0] e_da,
                              logic e_hb, logic [31:0] e_db);
    vec_t v;
    v.ev = ev; v.ar = ar; v.res = res; v.cmp = cmp; v.wa = wa; v.we = we;
    v.wr = wr; v.ra = ra; v.rb = rb;
    v.e_valid = e_valid; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_we = e_we; v.e_cmp = e_cmp; v.e_rdy = e_rdy;
    v.e_ha = e_ha; v.e_da = e_da; v.e_hb = e_hb; v.e_db = e_db;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ev, input logic [4:0] wa,
                        input logic [31:0] res, input logic cmp, input logic we);
    ex_valid_i      = ev;
    regfile_waddr_i = wa;
    alu_result_i    = res;
    alu_cmp_i       = cmp;
    regfile_we_i    = we;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    alu_ready_i   = 1'b1;
    flush_i       = 1'b0;
    wb_ready_i    = 1'b0;
    fwd_raddr_a_i = 5'd0;
    fwd_raddr_b_i = 5'd0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // ev ar res cmp wa we wr ra rb | valid waddr wdata we cmp rdy ha da hb db
    vecs[0] = mk(1,1,32'h1234,1,5,1,1, 5,0, 1,5,32'h1234,1,1, 1, 1,32'h1234, 0,0);
    vecs[1] = mk(0,1,32'h0,   0,0,0,1, 5,0, 0,0,32'h0,   0,0, 1, 0,32'h0,    0,0);
    vecs[2] = mk(1,1,32'hAAAA,0,7,1,0, 7,0, 1,7,32'hAAAA,1,0, 1, 1,32'hAAAA, 0,0);
    vecs[3] = mk(1,1,32'h5555,1,7,1,0, 7,0, 1,7,32'hAAAA,1,0, 0, 1,32'h5555, 0,0);
    vecs[4] = mk(0,1,32'h0,   0,0,0,1, 7,0, 1,7,32'h5555,1,1, 1, 1,32'h5555, 0,0);
    vecs[5] = mk(1,1,32'hDEAD,0,0,1,1, 0,7, 1,0,32'hDEAD,0,0, 1, 0,32'h0,    0,0);
    vecs[6] = mk(0,1,32'h0,   0,0,0,1, 0,7, 0,0,32'h0,   0,0, 1, 0,32'h0,    0,0);
    vecs[7] = mk(1,1,32'h33,  0,3,0,0, 3,0, 1,3,32'h33,  0,0, 1, 0,32'h0,    0,0);
    vecs[8] = mk(0,1,32'h0,   0,0,0,1, 3,3, 0,0,32'h0,   0,0, 1, 0,32'h0,    0,0);
    vecs[9] = mk(1,0,32'h99,  0,9,1,0, 9,0, 0,0,32'h0,   0,0, 1, 0,32'h0,    0,0);

    do_reset();
    check("rst wb_valid", wb_valid_o, 0);
    check("rst wb_we", wb_we_o, 0);
    check("rst wb_wdata", wb_wdata_o, 0);
    check("rst ex_ready", ex_ready_o, 1);
    check("rst stall_cnt", stall_cnt_o, 0);
    check("rst hit_a", fwd_hit_a_o, 0);

    // Table-driven single-step vectors; outputs checked just after each edge.
    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].ev, vecs[i].wa, vecs[i].res, vecs[i].cmp, vecs[i].we);
      alu_ready_i   = vecs[i].ar;
      wb_ready_i    = vecs[i].wr;
      fwd_raddr_a_i = vecs[i].ra;
      fwd_raddr_b_i = vecs[i].rb;
      tick();
      check($sformatf("v%0d wb_valid", i), wb_valid_o, vecs[i].e_valid);
      check($sformatf("v%0d wb_waddr", i), wb_waddr_o, vecs[i].e_waddr);
      check($sformatf("v%0d wb_wdata", i), wb_wdata_o, vecs[i].e_wdata);
      check($sformatf("v%0d wb_we", i), wb_we_o, vecs[i].e_we);
      check($sformatf("v%0d wb_cmp", i), wb_cmp_o, vecs[i].e_cmp);
      check($sformatf("v%0d ex_ready", i), ex_ready_o, vecs[i].e_rdy);
      check($sformatf("v%0d hit_a", i), fwd_hit_a_o, vecs[i].e_ha);
      check($sformatf("v%0d data_a", i), fwd_data_a_o, vecs[i].e_da);
      check($sformatf("v%0d hit_b", i), fwd_hit_b_o, vecs[i].e_hb);
      check($sformatf("v%0d data_b", i), fwd_data_b_o, vecs[i].e_db);
    end
    check("table stall_cnt", stall_cnt_o, 0);
    alu_ready_i = 1'b1;

    // Fill, stall on a third entry, then drain in order.
    do_reset();
    set_in(1, 5'd1, 32'd1, 0, 1); tick();
    check("fill1 head", wb_wdata_o, 1);
    set_in(1, 5'd2, 32'd2, 0, 1); tick();
    check("fill2 ex_ready", ex_ready_o, 0);
    set_in(1, 5'd3, 32'd3, 0, 1);
    tick(); tick(); tick();
    check("blocked stall_cnt", stall_cnt_o, 3);
    check("blocked head", wb_wdata_o, 1);
    wb_ready_i = 1'b1;
    #1;
    check("no ready bypass", ex_ready_o, 0);
    tick();
    check("drain1 head", wb_wdata_o, 2);
    check("drain1 ex_ready", ex_ready_o, 1);
    tick();
    check("drain2 head", wb_wdata_o, 3);
    check("drain2 waddr", wb_waddr_o, 3);
    set_in(0, 5'd0, 32'd0, 0, 0);
    tick();
    check("drain3 wb_valid", wb_valid_o, 0);
    check("drain stall_cnt", stall_cnt_o, 4);

    // Ten back-to-back push+pop cycles at occupancy 1.
    do_reset();
    set_in(1, 5'd4, 32'h100, 0, 1); tick();
    wb_ready_i    = 1'b1;
    fwd_raddr_a_i = 5'd4;
    for (int i = 0; i < 10; i++) begin
      set_in(1, 5'd4, 32'h101 + i, 0, 1);
      if (i == 0) begin
        #1;
        check("popping entry forwards", fwd_data_a_o, 32'h100);
      end
      tick();
      check($sformatf("b2b%0d head", i), wb_wdata_o, 32'h101 + i);
      check($sformatf("b2b%0d ex_ready", i), ex_ready_o, 1);
      check($sformatf("b2b%0d wb_valid", i), wb_valid_o, 1);
    end
    set_in(0, 5'd0, 32'd0, 0, 0);
    tick();
    check("b2b drained", wb_valid_o, 0);

    // Flush with a concurrent push while full.
    do_reset();
    set_in(1, 5'd1, 32'h11, 0, 1); tick();
    set_in(1, 5'd2, 32'h22, 0, 1); tick();
    set_in(1, 5'd3, 32'h33, 0, 1);
    fwd_raddr_a_i = 5'd2;
    #1;
    check("pre-flush hit_a", fwd_hit_a_o, 1);
    check("pre-flush data_a", fwd_data_a_o, 32'h22);
    flush_i    = 1'b1;
    wb_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    set_in(0, 5'd0, 32'd0, 0, 0);
    check("flush wb_valid", wb_valid_o, 0);
    check("flush ex_ready", ex_ready_o, 1);
    check("flush stall_cnt", stall_cnt_o, 1);
    check("flush hit_a", fwd_hit_a_o, 0);
    tick();
    check("post-flush wb_valid", wb_valid_o, 0);

    // Reset in the middle of draining.
    do_reset();
    set_in(1, 5'd5, 32'h55, 0, 1); tick();
    set_in(1, 5'd6, 32'h66, 0, 1); tick();
    set_in(0, 5'd0, 32'd0, 0, 0);
    wb_ready_i = 1'b1;
    tick();
    check("mid-drain head", wb_wdata_o, 32'h66);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid-reset wb_valid", wb_valid_o, 0);
    check("mid-reset ex_ready", ex_ready_o, 1);
    tick();
    check("post-reset wb_valid", wb_valid_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
